// File: rtl/toggle_ctrl_pkg.sv
// Shared mode/state encodings for the start/stop enable controller.
//   MODE_* : per-channel 2-bit run-time mode (2'b11 behaves as TOGGLE)
//   state_t: per-channel enable FSM state
package toggle_ctrl_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_TOGGLE  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_MOMENT  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

endpackage : toggle_ctrl_pkg

// File: rtl/toggle_ch.sv
// One channel of the enable controller: rising-edge detect, press lockout,
// OFF/ON FSM and registered press pulse.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   btn      : synchronised button level
//   mode     : TOGGLE / MOMENTARY / ONESHOT (11 = TOGGLE)
//   clr      : synchronous force-off, overrides everything else
//   en       : registered enable (state == ON)
//   press    : 1-cycle pulse per accepted press
module toggle_ch
    import toggle_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_W  = 4,
    parameter int unsigned HOLDOFF = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic [MODE_W-1:0] mode,
    input  logic              clr,
    output logic              en,
    output logic              press
);

    state_t            state;
    state_t            state_nxt;
    logic              btn_q;
    logic [HOLD_W-1:0] cnt;
    logic [HOLD_W-1:0] cnt_nxt;
    logic              press_nxt;
    logic              rise;
    logic              acc;

    // State register; btn_q resets high so a level held through reset is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            btn_q <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            btn_q <= btn;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    // Next-state: edge accept, lockout countdown, mode rule, clr override.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        rise      = btn & ~btn_q;
        acc       = rise & (cnt == '0) & ~clr;

        // Rises during lockout are dropped, not queued.
        if (acc) begin
            cnt_nxt = HOLD_W'(HOLDOFF);
        end else if (cnt != '0) begin
            cnt_nxt = cnt - HOLD_W'(1);
        end

        press_nxt = acc;

        case (mode)
            MODE_MOMENT:  state_nxt = btn ? ST_ON : ST_OFF;
            MODE_ONESHOT: state_nxt = acc ? ST_ON : ST_OFF;
            default: begin
                if (acc) begin
                    state_nxt = (state == ST_ON) ? ST_OFF : ST_ON;
                end
            end
        endcase

        if (clr) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
            press_nxt = 1'b0;
        end
    end

    assign en = (state == ST_ON);

endmodule : toggle_ch

// File: rtl/toggle_en_ctrl.sv
// N-channel start/stop enable controller for counter/stopwatch datapaths.
// Each channel is an independent toggle_ch instance.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   btn      : [N_CH]     synchronised button levels
//   mode     : [2*N_CH]   per-channel mode, ch i = mode[2i+1:2i]
//   clr      : [N_CH]     synchronous per-channel force-off
//   en       : [N_CH]     registered enables
//   press    : [N_CH]     1-cycle accepted-press pulses
module toggle_en_ctrl
    import toggle_ctrl_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned HOLD_W  = 4,
    parameter int unsigned HOLDOFF = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        btn,
    input  logic [MODE_W*N_CH-1:0] mode,
    input  logic [N_CH-1:0]        clr,
    output logic [N_CH-1:0]        en,
    output logic [N_CH-1:0]        press
);

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        toggle_ch #(
            .HOLD_W  (HOLD_W),
            .HOLDOFF (HOLDOFF)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[i]),
            .mode  (mode[MODE_W*i +: MODE_W]),
            .clr   (clr[i]),
            .en    (en[i]),
            .press (press[i])
        );
    end

endmodule : toggle_en_ctrl
